// File: rtl/mod_inv_seq.sv
// -----------------------------------------------------------------------------
// mod_inv_seq
// Sequential modular inverse: out_data = in_a^-1 mod in_m. It uses the binary
// extended Euclid algorithm, with one halving or one subtraction per cycle.
//
// Optional feature macro: MOD_INV_CYCLE_CNT_EN
//   When defined, an operation counter is built and the out_cycles port exists.
//   The counter saturates at 4*MOD_W. Timing is the same with or without it.
//
// Ports
//   clk         clock, single domain
//   a_rst_n     asynchronous active-low reset
//   in_vld      request valid
//   in_rdy      request ready, high while idle
//   in_a        operand a
//   in_m        modulus m, must be odd
//   in_id       request tag, returned on out_id
//   out_vld     result valid, held until out_rdy
//   out_rdy     result ready
//   out_data    a^-1 mod m, or 0 on error
//   out_err     no inverse exists, or the request was invalid
//   out_id      tag of the request
//   out_cycles  number of halve/subtract operations (macro builds only)
// -----------------------------------------------------------------------------
module mod_inv_seq #(
  parameter int MOD_W = 64,
  parameter int ID_W  = 8
`ifdef MOD_INV_CYCLE_CNT_EN
  ,
  localparam int CNT_W = $clog2(4*MOD_W+1)
`endif
) (
  input  logic             clk,
  input  logic             a_rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [MOD_W-1:0] in_a,
  input  logic [MOD_W-1:0] in_m,
  input  logic [ID_W-1:0]  in_id,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [MOD_W-1:0] out_data,
  output logic             out_err,
  output logic [ID_W-1:0]  out_id
`ifdef MOD_INV_CYCLE_CNT_EN
  ,
  output logic [CNT_W-1:0] out_cycles
`endif
);

  localparam logic [MOD_W-1:0] ZERO = {MOD_W{1'b0}};
  localparam logic [MOD_W-1:0] ONE  = {{(MOD_W-1){1'b0}}, 1'b1};
`ifdef MOD_INV_CYCLE_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(4*MOD_W);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
`endif

  // FIN is a one-cycle settle stage between the decision and the
  // presentation of the result. It makes out_vld rise k+2 cycles after the
  // accept edge.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2, DONE = 2'd3} state_t;

  state_t           state_r, state_s;
  logic [MOD_W-1:0] u_r, v_r, x1_r, x2_r, m_r;
  logic [MOD_W-1:0] u_s, v_s, x1_s, x2_s;
  logic             err_r;
  logic [ID_W-1:0]  id_r;
  logic             fin_s;
  logic [MOD_W-1:0] res_data_s;
  logic             res_err_s;
  logic [MOD_W-1:0] out_data_r;
  logic             out_err_r;
  logic [ID_W-1:0]  out_id_r;
`ifdef MOD_INV_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt_r, out_cycles_r;
`endif

  // half(x) = x/2 mod m, for odd m. An odd x adds (m+1)/2, which is written as
  // (m>>1)+1. This form cannot overflow when m = 2^MOD_W-1.
  function automatic logic [MOD_W-1:0] half_mod(input logic [MOD_W-1:0] x,
                                                input logic [MOD_W-1:0] m);
    logic [MOD_W:0] sum;
    if (x[0]) begin
      sum = {1'b0, x >> 1} + {2'b00, m[MOD_W-1:1]} + {{MOD_W{1'b0}}, 1'b1};
    end else begin
      sum = {1'b0, x >> 1};
    end
    return sum[MOD_W-1:0];
  endfunction

  // msub(x,y) = (x - y) mod m. It uses one extra bit to detect a borrow.
  function automatic logic [MOD_W-1:0] msub_mod(input logic [MOD_W-1:0] x,
                                                input logic [MOD_W-1:0] y,
                                                input logic [MOD_W-1:0] m);
    logic [MOD_W:0] diff;
    diff = {1'b0, x} - {1'b0, y};
    if (diff[MOD_W]) begin
      diff = diff + {1'b0, m};
    end else begin
      diff = diff;
    end
    return diff[MOD_W-1:0];
  endfunction

  assign in_rdy   = (state_r == IDLE);
  assign out_vld  = (state_r == DONE);
  assign out_data = out_data_r;
  assign out_err  = out_err_r;
  assign out_id   = out_id_r;
`ifdef MOD_INV_CYCLE_CNT_EN
  assign out_cycles = out_cycles_r;
`endif

  // Next state and one Euclid step. In CALC, the first matching rule wins.
  always_comb begin
    state_s    = state_r;
    u_s        = u_r;
    v_s        = v_r;
    x1_s       = x1_r;
    x2_s       = x2_r;
    fin_s      = 1'b0;
    res_data_s = ZERO;
    res_err_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_vld) state_s = CALC;
        else        state_s = IDLE;
      end
      CALC: begin
        if (err_r) begin
          fin_s     = 1'b1;
          res_err_s = 1'b1;
        end else if (v_r == ONE) begin
          fin_s      = 1'b1;
          res_data_s = x2_r;
        end else if (u_r == ONE) begin
          fin_s      = 1'b1;
          res_data_s = x1_r;
        end else if ((u_r == ZERO) || (v_r == ZERO)) begin
          fin_s     = 1'b1;   // gcd(a,m) != 1
          res_err_s = 1'b1;
        end else if (!u_r[0]) begin
          u_s  = u_r >> 1;
          x1_s = half_mod(x1_r, m_r);
        end else if (!v_r[0]) begin
          v_s  = v_r >> 1;
          x2_s = half_mod(x2_r, m_r);
        end else if (u_r >= v_r) begin
          u_s  = u_r - v_r;
          x1_s = msub_mod(x1_r, x2_r, m_r);
        end else begin
          v_s  = v_r - u_r;
          x2_s = msub_mod(x2_r, x1_r, m_r);
        end
        if (fin_s) state_s = FIN;
        else       state_s = CALC;
      end
      FIN: begin
        state_s = DONE;
      end
      DONE: begin
        if (out_rdy) state_s = IDLE;
        else         state_s = DONE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, working registers and held output registers.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_r    <= IDLE;
      u_r        <= ZERO;
      v_r        <= ZERO;
      x1_r       <= ZERO;
      x2_r       <= ZERO;
      m_r        <= ZERO;
      err_r      <= 1'b0;
      id_r       <= {ID_W{1'b0}};
      out_data_r <= ZERO;
      out_err_r  <= 1'b0;
      out_id_r   <= {ID_W{1'b0}};
`ifdef MOD_INV_CYCLE_CNT_EN
      cnt_r        <= {CNT_W{1'b0}};
      out_cycles_r <= {CNT_W{1'b0}};
`endif
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (in_vld) begin
            u_r   <= in_a;
            v_r   <= in_m;
            x1_r  <= ONE;
            x2_r  <= ZERO;
            m_r   <= in_m;
            id_r  <= in_id;
            err_r <= (!in_m[0]) || (in_a == ZERO) || (in_a >= in_m);
`ifdef MOD_INV_CYCLE_CNT_EN
            cnt_r <= {CNT_W{1'b0}};
`endif
          end
        end
        CALC: begin
          u_r  <= u_s;
          v_r  <= v_s;
          x1_r <= x1_s;
          x2_r <= x2_s;
          if (fin_s) begin
            out_data_r <= res_data_s;
            out_err_r  <= res_err_s;
            out_id_r   <= id_r;
`ifdef MOD_INV_CYCLE_CNT_EN
            out_cycles_r <= cnt_r;
`endif
          end
`ifdef MOD_INV_CYCLE_CNT_EN
          // Every non-final CALC cycle is one halve or subtract operation.
          if (!fin_s && (cnt_r != CNT_MAX)) cnt_r <= cnt_r + CNT_ONE;
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_inv_seq.sv
module tb_mod_inv_seq;
  localparam int MOD_W = 64;
  localparam int ID_W  = 8;
  localparam int CNT_W = $clog2(4*MOD_W+1);

  logic             clk = 1'b0;
  logic             a_rst_n = 1'b0;
  logic             in_vld = 1'b0;
  logic             in_rdy;
  logic [MOD_W-1:0] in_a = '0;
  logic [MOD_W-1:0] in_m = '0;
  logic [ID_W-1:0]  in_id = '0;
  logic             out_vld;
  logic             out_rdy = 1'b0;
  logic [MOD_W-1:0] out_data;
  logic             out_err;
  logic [ID_W-1:0]  out_id;
`ifdef MOD_INV_CYCLE_CNT_EN
  logic [CNT_W-1:0] out_cycles;
`endif

  int checks = 0;
  int failures = 0;

  mod_inv_seq #(.MOD_W(MOD_W), .ID_W(ID_W)) dut (
    .clk(clk), .a_rst_n(a_rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_a(in_a), .in_m(in_m), .in_id(in_id),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .out_err(out_err), .out_id(out_id)
`ifdef MOD_INV_CYCLE_CNT_EN
    , .out_cycles(out_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [63:0] model_gcd(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] x, y, t;
    x = a; y = b;
    while (y != 64'd0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  // Classic extended Euclid with division. Coefficients are kept mod m.
  function automatic logic [63:0] model_inv(input logic [63:0] a, input logic [63:0] m);
    logic [127:0] r0, r1, t0, t1, q, tmp, mm;
    mm = {64'd0, m}; r0 = mm; r1 = {64'd0, a}; t0 = 128'd0; t1 = 128'd1;
    while (r1 != 128'd0) begin
      q = r0 / r1; tmp = r0 - q * r1; r0 = r1; r1 = tmp;
      tmp = (t0 + mm - ((q * t1) % mm)) % mm; t0 = t1; t1 = tmp;
    end
    return t0[63:0];
  endfunction

  // Operation count k from the halve/subtract rules on (u,v) alone.
  function automatic int model_steps(input logic [63:0] a, input logic [63:0] m);
    logic [63:0] u, v;
    int k;
    if (!m[0] || a == 64'd0 || a >= m) return 0;
    u = a; v = m; k = 0;
    while (k < 1000) begin
      if (v == 64'd1 || u == 64'd1 || u == 64'd0 || v == 64'd0) break;
      if (!u[0]) u = u >> 1;
      else if (!v[0]) v = v >> 1;
      else if (u >= v) u = u - v;
      else v = v - u;
      k++;
    end
    return k;
  endfunction

  // ---------------- transaction helpers ----------------
  task automatic wait_vld(output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      lat++;
      if (out_vld) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL out_vld_timeout got=0 exp=1");
    end
  endtask

  task automatic drain();
    @(negedge clk); out_rdy = 1'b1;
    @(posedge clk); #1; out_rdy = 1'b0;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] m, input logic [7:0] id);
    int n;
    @(negedge clk);
    in_a = a; in_m = m; in_id = id; in_vld = 1'b1;
    n = 0;
    while (!in_rdy && n < 20) begin @(negedge clk); n++; end
    if (!in_rdy) begin
      checks++; failures++;
      $display("FAIL in_rdy_timeout got=0 exp=1");
    end
    @(posedge clk); #1; in_vld = 1'b0;
  endtask

  task automatic run_req(input logic [63:0] a, input logic [63:0] m, input logic [7:0] id,
                         output logic [63:0] d, output logic e, output logic [7:0] oid,
                         output int lat, output int cyc);
    bit ok;
    send(a, m, id);
    wait_vld(lat, ok);
    d = out_data; e = out_err; oid = out_id;
`ifdef MOD_INV_CYCLE_CNT_EN
    cyc = int'(out_cycles);
`else
    cyc = -1;
`endif
    drain();
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] m;
    logic [7:0]  id;
    logic [63:0] data;
    logic        err;
    int          k;    // -1: take k from the model
  } vec_t;

  vec_t vt[12];

  initial begin
    logic [63:0] d, a, m, g, d0;
    logic [127:0] p;
    logic        e;
    logic [7:0]  oid;
    int          lat, cyc, k;
    bit          ok;

    vt[0]  = '{64'd3, 64'd7, 8'd5, 64'd5, 1'b0, 3};
    vt[1]  = '{64'd1, 64'd13, 8'd6, 64'd1, 1'b0, 0};
    vt[2]  = '{64'd2, 64'h1FFF_FFFF_FFFF_FFFF, 8'd7, 64'h1000_0000_0000_0000, 1'b0, 1};
    vt[3]  = '{64'd6, 64'd9, 8'd8, 64'd0, 1'b1, 4};
    vt[4]  = '{64'd3, 64'd8, 8'd9, 64'd0, 1'b1, 0};
    vt[5]  = '{64'd0, 64'd7, 8'd10, 64'd0, 1'b1, 0};
    vt[6]  = '{64'd9, 64'd7, 8'd11, 64'd0, 1'b1, 0};
    vt[7]  = '{64'd0, 64'd1, 8'd12, 64'd0, 1'b1, 0};
    vt[8]  = '{64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'd13, 64'h8000_0000_0000_0000, 1'b0, 1};
    vt[9]  = '{64'd5, 64'd11, 8'd14, 64'd9, 1'b0, 4};
    vt[10] = '{64'd7, 64'd7, 8'd15, 64'd0, 1'b1, 0};
    vt[11] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 8'hA5,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, -1};

    // Reset state.
    #12;
    check("rst_in_rdy", in_rdy, 1'b1);
    check("rst_out_vld", out_vld, 1'b0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_err", out_err, 1'b0);
    check("rst_out_id", out_id, 8'd0);
`ifdef MOD_INV_CYCLE_CNT_EN
    check("rst_out_cycles", out_cycles, 9'd0);
`endif
    @(negedge clk); a_rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      run_req(vt[i].a, vt[i].m, vt[i].id, d, e, oid, lat, cyc);
      k = (vt[i].k < 0) ? model_steps(vt[i].a, vt[i].m) : vt[i].k;
      check($sformatf("vec%0d_data", i), d, vt[i].data);
      check($sformatf("vec%0d_err", i), e, vt[i].err);
      check($sformatf("vec%0d_id", i), oid, vt[i].id);
      check($sformatf("vec%0d_latency", i), lat, k + 2);
`ifdef MOD_INV_CYCLE_CNT_EN
      check($sformatf("vec%0d_cycles", i), cyc, k);
`endif
    end

    // Backpressure: outputs held, busy input ignored, back-to-back accept.
    send(64'd3, 64'd7, 8'h21);
    wait_vld(lat, ok);
    check("bp_latency", lat, 5);
    @(negedge clk);
    in_a = 64'd5; in_m = 64'd11; in_id = 8'h22; in_vld = 1'b1;
    d0 = out_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_vld", out_vld, 1'b1);
      check("bp_hold_in_rdy", in_rdy, 1'b0);
      check("bp_hold_data", out_data, 64'd5);
      check("bp_hold_id", out_id, 8'h21);
    end
    check("bp_hold_data_stable", out_data, d0);
    out_rdy = 1'b1;
    @(posedge clk); #1; out_rdy = 1'b0;
    check("bp_after_xfer_vld", out_vld, 1'b0);
    check("bp_after_xfer_in_rdy", in_rdy, 1'b1);
    @(posedge clk); #1; in_vld = 1'b0;
    check("bp_second_accepted", in_rdy, 1'b0);
    wait_vld(lat, ok);
    check("bp_second_latency", lat, 6);
    check("bp_second_data", out_data, 64'd9);
    check("bp_second_id", out_id, 8'h22);
    drain();

    // Reset during CALC.
    send(64'h1234_5678_9ABC_DEF1, 64'hFFFF_FFFF_FFFF_FFC5, 8'h33);
    repeat (3) @(posedge clk);
    #2; a_rst_n = 1'b0;
    #1;
    check("rstcalc_out_vld", out_vld, 1'b0);
    check("rstcalc_in_rdy", in_rdy, 1'b1);
    @(negedge clk); a_rst_n = 1'b1;
    run_req(64'd5, 64'd11, 8'h44, d, e, oid, lat, cyc);
    check("rstcalc_next_data", d, 64'd9);
    check("rstcalc_next_err", e, 1'b0);
    check("rstcalc_next_id", oid, 8'h44);

    // Random sweep against the model.
    for (int i = 0; i < 60; i++) begin
      if (i % 3 == 0) begin
        g = 64'(3 + 2 * $urandom_range(0, 40));
        m = g * {32'd0, ($urandom | 32'h0000_1001)};
        a = g * 64'($urandom_range(1, 1000));
      end else begin
        m = {$urandom, $urandom} | 64'd1;
        if (m == 64'd1) m = 64'd3;
        a = {$urandom, $urandom} % m;
        if (a == 64'd0) a = 64'd1;
      end
      run_req(a, m, 8'(i), d, e, oid, lat, cyc);
      k = model_steps(a, m);
      g = model_gcd(a, m);
      if (g == 64'd1) begin
        check("rnd_err", e, 1'b0);
        check("rnd_data", d, model_inv(a, m));
        p = ({64'd0, a} * {64'd0, d}) % {64'd0, m};
        check("rnd_product", p, 128'd1);
      end else begin
        check("rnd_err_gcd", e, 1'b1);
        check("rnd_data_gcd", d, 64'd0);
      end
      check("rnd_id", oid, 8'(i));
      check("rnd_latency", lat, k + 2);
      check("rnd_k_bound", (k <= 256) ? 1 : 0, 1);
`ifdef MOD_INV_CYCLE_CNT_EN
      check("rnd_cycles", cyc, k);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
